// File: rtl/serial_comp_pkg.sv
// Shared definitions for the bit-serial complement unit: FSM encodings and
// mode values.
package serial_comp_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic MODE_ONES = 1'b0;
  localparam logic MODE_TWOS = 1'b1;

endpackage

// File: rtl/comp_bit_cell.sv
// One bit slice of the serial complementer. One's complement always inverts.
// Two's complement copies bits up to and including the first 1, then inverts.
module comp_bit_cell
  import serial_comp_pkg::*;
(
  input  logic b,
  input  logic mode_q,
  input  logic seen1,
  output logic obit,
  output logic seen1_next
);

  // Copy phase lasts only while in two's-complement mode and no 1 seen yet.
  always_comb begin
    obit       = (mode_q == MODE_TWOS && !seen1) ? b : ~b;
    seen1_next = seen1 | b;
  end

endmodule

// File: rtl/serial_complementer.sv
// Bit-serial one's/two's complement unit, LSB first, one bit per clock.
// Handshake: start sampled in IDLE, single-cycle done pulse, C held afterwards.
// Optional build macro SERIAL_COMP_OVF_EN adds the ovf output, which flags
// negation of the most-negative value.
module serial_complementer
  import serial_comp_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic [N-1:0] A,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] C
`ifdef SERIAL_COMP_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state_q, state_d;
  logic [N-1:0]  sreg_q, sreg_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [N-1:0]  c_q, c_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          seen1_q, seen1_d;
  logic          mode_q, mode_d;
`ifdef SERIAL_COMP_OVF_EN
  logic          msb_q, msb_d;
  logic          ovf_q, ovf_d;
`endif

  logic obit, seen1_nx;

  comp_bit_cell u_cell (
    .b          (sreg_q[0]),
    .mode_q     (mode_q),
    .seen1      (seen1_q),
    .obit       (obit),
    .seen1_next (seen1_nx)
  );

  // State register; reset aborts any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      acc_q   <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      seen1_q <= 1'b0;
      mode_q  <= MODE_ONES;
`ifdef SERIAL_COMP_OVF_EN
      msb_q   <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      seen1_q <= seen1_d;
      mode_q  <= mode_d;
`ifdef SERIAL_COMP_OVF_EN
      msb_q   <= msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Next-state: latch operands in IDLE, shift one bit per SHIFT cycle,
  // publish the result on the last shift.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    acc_d   = acc_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    seen1_d = seen1_q;
    mode_d  = mode_q;
`ifdef SERIAL_COMP_OVF_EN
    msb_d   = msb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sreg_d  = A;
          mode_d  = mode;
          cnt_d   = '0;
          seen1_d = 1'b0;
`ifdef SERIAL_COMP_OVF_EN
          msb_d   = A[N-1];
`endif
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        seen1_d = seen1_nx;
        sreg_d  = sreg_q >> 1;
        acc_d   = {obit, acc_q[N-1:1]};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          c_d     = acc_d;
`ifdef SERIAL_COMP_OVF_EN
          // Final bit stays 1 only when negating 100..0.
          ovf_d   = mode_q & msb_q & obit;
`endif
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign C    = c_q;
`ifdef SERIAL_COMP_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
